uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_framer_if.sv | 28 ++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_rx_framer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer: FSM state encoding,
// error codes reported on err_code, and the default frame start byte.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Signal bundle of the framer: byte input from the UART receiver, the
// ready/valid payload stream and the frame status outputs.
// slave is the framer side, master is the side that feeds and drains it.
interface uart_rx_framer_if;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_drop;

  modport slave (
    input  rxd_data, rxd_flag, out_ready,
    output out_data, out_valid, out_last, frame_len, frame_ok, frame_err,
           err_code, rx_drop
  );

  modport master (
    output rxd_data, rxd_flag, out_ready,
    input  out_data, out_valid, out_last, frame_len, frame_ok, frame_err,
           err_code, rx_drop
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: MAX_LEN x 8 register array with a single
// synchronous write port and an asynchronous read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  // Write the incoming payload byte at the framer's write pointer.
  // NOTE: storage has no reset; contents are only read back after being
  // written in the same frame, and a reset would cost a mux on every bit.
  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// Frame parser for bytes from a UART receiver: HDR, LEN, payload, CHK.
// A frame with a valid checksum is replayed on a ready/valid stream.
// Optional inter-byte timeout: define UART_FRAMER_TIMEOUT_EN.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 104166
) (
  input  logic             clk50M,
  input  logic             rst,
  uart_rx_framer_if.slave  bus
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       rx_drop_q, rx_drop_d;
  logic       buf_we;
  logic       load_next;
  logic [7:0] buf_rdata;

`ifdef UART_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk50M),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.rxd_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Next-state and output decode: parse one byte per rxd_flag, replay in SEND.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_len_d = frame_len_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_drop_d   = 1'b0;
    buf_we      = 1'b0;
    // Present the next byte when nothing is held or the held one is taken.
    load_next   = !out_valid_q || (bus.out_ready && !out_last_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.rxd_flag && bus.rxd_data == HDR_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (bus.rxd_flag) begin
          if (bus.rxd_data == 8'd0 || bus.rxd_data > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d    = bus.rxd_data;
            sum_d    = 8'd0;
            wr_ptr_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.rxd_flag) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + bus.rxd_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == len_q - 8'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (bus.rxd_flag) begin
          // The checksum covers LEN as well as the payload.
          if (bus.rxd_data == 8'(sum_q + len_q)) begin
            frame_ok_d  = 1'b1;
            frame_len_d = len_q;
            rd_ptr_d    = 8'd0;
            state_d     = ST_SEND;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_SEND: begin
        rx_drop_d = bus.rxd_flag;
        if (load_next) begin
          out_data_d  = buf_rdata;
          out_last_d  = (rd_ptr_q == len_q - 8'd1);
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 8'd1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_FRAMER_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) &&
        !bus.rxd_flag) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers; reset abandons any frame without pulses.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_len_q <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      rx_drop_q   <= 1'b0;
`ifdef UART_FRAMER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_len_q <= frame_len_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      rx_drop_q   <= rx_drop_d;
`ifdef UART_FRAMER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_len = frame_len_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.rx_drop   = rx_drop_q;

endmodule
